// File: rtl/conv_pkg.sv
// Shared constants and types for the layer-0 convolution and layer-1 max-pool stages.
package conv_pkg;

    localparam int DATA_W = 20;
    localparam int IMG_W  = 64;
    localparam int ADDR_W = 12;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_CMP  = 3'd5,
        ST_WR   = 3'd6
    } state_e;

endpackage

// File: rtl/layer1_maxpool_if.sv
// Control handshake and shared layer-0/layer-1 memory bus of the max-pool stage.
interface layer1_maxpool_if #(
    parameter int DATA_W = conv_pkg::DATA_W
);
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        crd;
    logic [conv_pkg::ADDR_W-1:0] caddr_rd;
    logic [DATA_W-1:0]           cdata_rd;
    logic                        cwr;
    logic [conv_pkg::ADDR_W-1:0] caddr_wr;
    logic [DATA_W-1:0]           cdata_wr;
    logic [2:0]                  csel;

    modport master (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

endinterface

// File: rtl/smax2.sv
// Signed two-input maximum; on a tie the a_i operand (the earlier sample) wins.
module smax2 #(
    parameter int W = conv_pkg::DATA_W
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] y_o
);
    import conv_pkg::*;

    // Strict greater-than so equal values keep the earlier operand.
    always_comb begin
        if (b_i > a_i) begin
            y_o = b_i;
        end else begin
            y_o = a_i;
        end
    end

endmodule

// File: rtl/layer1_maxpool.sv
// 2x2 max-pool of the layer-0 map into layer 1: four reads, one compare cycle and
// one write per output pixel over the shared memory bus.
module layer1_maxpool #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 20
) (
    input  logic            clk,
    input  logic            reset,
    layer1_maxpool_if.slave bus
);
    import conv_pkg::*;

    localparam int HW = $clog2(IMG_W) - 1;
    localparam int OW = 2 * HW;
    localparam int PW = OW + 2;
    localparam logic [OW-1:0] O_LAST = {OW{1'b1}};

    state_e                   st_q, st_d;
    logic [OW-1:0]            o_q, o_d;
    logic signed [DATA_W-1:0] max_q, max_d, cmp_s;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     crd_q, crd_d;
    logic                     cwr_q, cwr_d;
    logic [ADDR_W-1:0]        caddr_rd_q, caddr_rd_d;
    logic [ADDR_W-1:0]        caddr_wr_q, caddr_wr_d;
    logic [DATA_W-1:0]        cdata_wr_q, cdata_wr_d;
    logic [2:0]               csel_q, csel_d;

    // {row, dy, col, dx} is 2r*IMG_W + dy*IMG_W + 2c + dx because IMG_W is a power of two.
    function automatic logic [ADDR_W-1:0] win_addr(input logic [OW-1:0] o,
                                                   input logic dy, input logic dx);
        logic [PW-1:0] a;
        a = {o[OW-1:HW], dy, o[HW-1:0], dx};
        return ADDR_W'(a);
    endfunction

    smax2 #(.W(DATA_W)) u_smax (
        .a_i (max_q),
        .b_i (bus.cdata_rd),
        .y_o (cmp_s)
    );

    // Sequencer: read data arrives one cycle after each read, so RD1..CMP fold it in.
    always_comb begin
        st_d  = st_q;
        o_d   = o_q;
        max_d = max_q;
        case (st_q)
            ST_IDLE: begin
                if (bus.start) begin
                    st_d = ST_RD0;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_RD0: st_d = ST_RD1;
            ST_RD1: begin
                st_d  = ST_RD2;
                max_d = bus.cdata_rd;
            end
            ST_RD2: begin
                st_d  = ST_RD3;
                max_d = cmp_s;
            end
            ST_RD3: begin
                st_d  = ST_CMP;
                max_d = cmp_s;
            end
            ST_CMP: begin
                st_d  = ST_WR;
                max_d = cmp_s;
            end
            ST_WR: begin
                if (o_q == O_LAST) begin
                    st_d = ST_IDLE;
                    o_d  = {OW{1'b0}};
                end else begin
                    st_d = ST_RD0;
                    o_d  = o_q + OW'(1);
                end
            end
            default: begin
                st_d  = ST_IDLE;
                o_d   = {OW{1'b0}};
                max_d = {DATA_W{1'b0}};
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they register alongside it.
    always_comb begin
        busy_d     = (st_d != ST_IDLE);
        done_d     = 1'b0;
        crd_d      = 1'b0;
        cwr_d      = 1'b0;
        csel_d     = CSEL_NONE;
        caddr_rd_d = {ADDR_W{1'b0}};
        caddr_wr_d = {ADDR_W{1'b0}};
        cdata_wr_d = {DATA_W{1'b0}};
        case (st_d)
            ST_RD0: begin
                crd_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_rd_d = win_addr(o_d, 1'b0, 1'b0);
            end
            ST_RD1: begin
                crd_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_rd_d = win_addr(o_d, 1'b0, 1'b1);
            end
            ST_RD2: begin
                crd_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_rd_d = win_addr(o_d, 1'b1, 1'b0);
            end
            ST_RD3: begin
                crd_d      = 1'b1;
                csel_d     = CSEL_L0;
                caddr_rd_d = win_addr(o_d, 1'b1, 1'b1);
            end
            ST_WR: begin
                cwr_d      = 1'b1;
                csel_d     = CSEL_L1;
                caddr_wr_d = ADDR_W'(o_d);
                cdata_wr_d = max_d;
                done_d     = (o_d == O_LAST);
            end
            default: begin
                csel_d = CSEL_NONE;
            end
        endcase
    end

    // State, index, running maximum and every bus output share one register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= ST_IDLE;
            o_q        <= {OW{1'b0}};
            max_q      <= {DATA_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= {ADDR_W{1'b0}};
            caddr_wr_q <= {ADDR_W{1'b0}};
            cdata_wr_q <= {DATA_W{1'b0}};
            csel_q     <= CSEL_NONE;
        end else begin
            st_q       <= st_d;
            o_q        <= o_d;
            max_q      <= max_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crd      = crd_q;
    assign bus.cwr      = cwr_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.csel     = csel_q;

endmodule

// File: tb/tb_layer1_maxpool.sv
// Self-checking bench for layer1_maxpool: memory model, protocol monitor and a
// window-max reference computed directly from the layer-0 array.
module tb_layer1_maxpool;

    localparam int IMG_W  = 64;
    localparam int DATA_W = 20;
    localparam int HALF   = IMG_W / 2;
    localparam int NOUT   = HALF * HALF;
    localparam int NPIX   = IMG_W * IMG_W;

    logic clk = 1'b0;
    logic reset;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int rd_cnt   = 0;
    int wr_o     = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int rd0_cyc  = -1;
    int done_cyc = -1;
    int first_wr = -1;

    logic [DATA_W-1:0] l0 [NPIX];
    logic [DATA_W-1:0] l1 [NOUT];

    layer1_maxpool_if #(.DATA_W(DATA_W)) bus ();

    layer1_maxpool #(.IMG_W(IMG_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int win_pix(input int o, input int k);
        int b;
        b = 2 * (o / HALF) * IMG_W + 2 * (o % HALF);
        case (k)
            0:       return b;
            1:       return b + 1;
            2:       return b + IMG_W;
            default: return b + IMG_W + 1;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] ref_pool(input int o);
        int best;
        int v;
        best = int'($signed(l0[win_pix(o, 0)]));
        for (int k = 1; k < 4; k++) begin
            v = int'($signed(l0[win_pix(o, k)]));
            if (v > best) best = v;
        end
        return best[DATA_W-1:0];
    endfunction

    // One clock: memory answers last cycle's read, then the protocol monitor runs.
    task automatic tick();
        logic              rd_s;
        logic              rst_s;
        logic [11:0]       ra_s;
        logic [11:0]       exp_a;
        logic [2:0]        exp_sel;
        rd_s  = bus.crd;
        ra_s  = bus.caddr_rd;
        rst_s = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_s === 1'b1) bus.cdata_rd = l0[ra_s];
        else               bus.cdata_rd = DATA_W'($urandom);
        if (rst_s === 1'b1) begin
            rd_cnt = 0;
            wr_o   = 0;
        end
        total++;
        if (bus.crd === 1'b1 && bus.cwr === 1'b1) begin
            bad++;
            $display("FAIL strobe_excl: crd=%b cwr=%b at cycle %0d, required not both high",
                     bus.crd, bus.cwr, cyc);
        end
        exp_sel = (bus.crd === 1'b1) ? 3'b001 : ((bus.cwr === 1'b1) ? 3'b011 : 3'b000);
        total++;
        if (bus.csel !== exp_sel) begin
            bad++;
            $display("FAIL csel: got %b required %b at cycle %0d", bus.csel, exp_sel, cyc);
        end
        if (bus.crd === 1'b1) begin
            if (rd_cnt == 0) rd0_cyc = cyc;
            exp_a = 12'(win_pix(rd_cnt / 4, rd_cnt % 4));
            total++;
            if (bus.caddr_rd !== exp_a) begin
                bad++;
                $display("FAIL rd_addr: got %0d required %0d (read #%0d)", bus.caddr_rd, exp_a, rd_cnt);
            end
            rd_cnt++;
        end
        if (bus.cwr === 1'b1) begin
            total++;
            if (bus.caddr_wr !== 12'(wr_o)) begin
                bad++;
                $display("FAIL wr_addr: got %0d required %0d", bus.caddr_wr, wr_o);
            end
            if (first_wr < 0) first_wr = int'(bus.caddr_wr);
            if (int'(bus.caddr_wr) < NOUT) l1[bus.caddr_wr[9:0]] = bus.cdata_wr;
            wr_o++;
            wr_cnt++;
        end
        if (bus.done === 1'b1) begin
            total++;
            if (bus.cwr !== 1'b1) begin
                bad++;
                $display("FAIL done_with_wr: cwr=%b required 1 when done pulses", bus.cwr);
            end
            done_cnt++;
            done_cyc = cyc;
            rd_cnt   = 0;
            wr_o     = 0;
        end
    endtask

    // Full pass: start pulse, bounded wait for done, then compare every layer-1 pixel.
    task automatic run_pass(input bit repulse, input string tag);
        int t0;
        int shown;
        bit fin;
        for (int i = 0; i < NOUT; i++) l1[i] = 'x;
        wr_cnt = 0; done_cnt = 0; rd0_cyc = -1; done_cyc = -1; first_wr = -1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.crd !== 1'b1) begin
            bad++;
            $display("FAIL %s_start: busy=%b crd=%b required 1 1", tag, bus.busy, bus.crd);
        end
        t0 = cyc; fin = 1'b0;
        while (!fin && (cyc - t0) < 7000) begin
            if (repulse && ((cyc - t0) % 997) == 13 && (cyc - t0) < 6000) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            if (done_cnt != 0) fin = 1'b1;
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL %s_timeout: no done within 7000 cycles, writes=%0d", tag, wr_cnt);
        end
        repeat (12) tick();
        total++;
        if (wr_cnt != NOUT) begin
            bad++;
            $display("FAIL %s_wr_count: got %0d required %0d", tag, wr_cnt, NOUT);
        end
        total++;
        if (done_cnt != 1) begin
            bad++;
            $display("FAIL %s_done_count: got %0d required 1", tag, done_cnt);
        end
        total++;
        if (done_cyc - rd0_cyc + 1 != 6 * NOUT) begin
            bad++;
            $display("FAIL %s_latency: got %0d cycles required %0d", tag, done_cyc - rd0_cyc + 1, 6 * NOUT);
        end
        total++;
        if (bus.busy !== 1'b0 || first_wr != 0) begin
            bad++;
            $display("FAIL %s_idle_after: busy=%b first_wr=%0d required 0 0", tag, bus.busy, first_wr);
        end
        shown = 0;
        for (int o = 0; o < NOUT; o++) begin
            total++;
            if (l1[o] !== ref_pool(o)) begin
                bad++;
                if (shown < 8) $display("FAIL %s_pixel[%0d]: got %h required %h", tag, o, l1[o], ref_pool(o));
                shown++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.cdata_rd = '0;
        repeat (3) tick();
        total++;
        if ({bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr, bus.csel} !== 51'd0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b crd=%b cwr=%b ra=%h wa=%h wd=%h csel=%b required all 0",
                     bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr, bus.csel);
        end
        reset = 1'b0;
        repeat (4) tick();
        total++;
        if (bus.busy !== 1'b0 || bus.crd !== 1'b0 || bus.cwr !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b crd=%b cwr=%b required 0 0 0", bus.busy, bus.crd, bus.cwr);
        end
    endtask

    task automatic test_ramp();
        for (int a = 0; a < NPIX; a++) l0[a] = DATA_W'(a);
        run_pass(1'b0, "ramp");
        total++;
        if (l1[0] !== 20'd65) begin
            bad++;
            $display("FAIL ramp_first: got %0d required 65", l1[0]);
        end
        total++;
        if (l1[NOUT-1] !== 20'd4095) begin
            bad++;
            $display("FAIL ramp_last: got %0d required 4095", l1[NOUT-1]);
        end
        for (int o = 0; o < NOUT; o++) begin
            total++;
            if (l1[o] !== DATA_W'(win_pix(o, 0) + IMG_W + 1)) begin
                bad++;
                $display("FAIL ramp_formula[%0d]: got %0d required %0d", o, l1[o], win_pix(o, 0) + IMG_W + 1);
            end
        end
    endtask

    task automatic test_negative();
        for (int a = 0; a < NPIX; a++) l0[a] = {1'b1, 19'($urandom)};
        l0[win_pix(37, 0)] = 20'hFFFFB;
        l0[win_pix(37, 1)] = 20'hFFFFD;
        l0[win_pix(37, 2)] = 20'hFFFF7;
        l0[win_pix(37, 3)] = 20'hFFFFD;
        run_pass(1'b0, "negative");
        total++;
        if (l1[37] !== 20'hFFFFD) begin
            bad++;
            $display("FAIL negative_window: got %h required fffff d", l1[37]);
        end
    endtask

    task automatic test_maxpos();
        int wins [4];
        wins = '{0, 333, 777, NOUT - 1};
        for (int a = 0; a < NPIX; a++) l0[a] = 20'h80000;
        for (int k = 0; k < 4; k++) l0[win_pix(wins[k], k)] = 20'h7FFFF;
        run_pass(1'b0, "maxpos");
        for (int k = 0; k < 4; k++) begin
            total++;
            if (l1[wins[k]] !== 20'h7FFFF) begin
                bad++;
                $display("FAIL maxpos_k%0d: got %h required 7ffff", k, l1[wins[k]]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < NPIX; a++) l0[a] = DATA_W'($urandom);
        run_pass(1'b1, "repulse");
        for (int a = 0; a < NPIX; a++) l0[a] = DATA_W'($urandom);
        run_pass(1'b0, "rerun");
    endtask

    task automatic test_reset_mid();
        int t0;
        int wr_before;
        bit found;
        logic [11:0] rd2_addr;
        rd2_addr = 12'(win_pix(300, 2));
        for (int a = 0; a < NPIX; a++) l0[a] = DATA_W'($urandom);
        wr_cnt = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t0 = cyc; found = 1'b0;
        while (!found && (cyc - t0) < 3000) begin
            tick();
            if (bus.crd === 1'b1 && bus.caddr_rd === rd2_addr) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL midreset_reach: RD2 of o=300 (addr %0d) not seen within 3000 cycles", rd2_addr);
        end
        wr_before = wr_cnt;
        reset = 1'b1;
        tick();
        total++;
        if ({bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr, bus.csel} !== 51'd0) begin
            bad++;
            $display("FAIL midreset_outputs: busy=%b done=%b crd=%b cwr=%b ra=%h wa=%h wd=%h csel=%b required all 0",
                     bus.busy, bus.done, bus.crd, bus.cwr, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr, bus.csel);
        end
        total++;
        if (wr_cnt != wr_before || wr_before != 300) begin
            bad++;
            $display("FAIL midreset_writes: before=%0d after=%0d required 300 300", wr_before, wr_cnt);
        end
        reset = 1'b0;
        repeat (5) tick();
        total++;
        if (bus.busy !== 1'b0 || bus.crd !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: busy=%b crd=%b required 0 0", bus.busy, bus.crd);
        end
        run_pass(1'b0, "post_reset");
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.cdata_rd = '0;
        test_reset();
        test_ramp();
        test_negative();
        test_maxpos();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
